// File: rtl/fft_sdf_delay_buffer_if.sv
`default_nettype none
// ============================================================================
// fft_sdf_delay_buffer_if : stage-side bus of the SDF delay buffer
// Rev 1.0
// ============================================================================
interface fft_sdf_delay_buffer_if #(
  parameter int WL    = 18,
  parameter int CNT_W = 4
);
  logic                 flush;
  logic                 in_valid;
  logic signed [WL:0]   in_real;
  logic signed [WL:0]   in_imag;
  logic signed [WL:0]   fb_real;
  logic signed [WL:0]   fb_imag;
  logic signed [WL:0]   dly_real;
  logic signed [WL:0]   dly_imag;
  logic                 sel;
  logic                 out_valid;
  logic [CNT_W:0]       phase_cnt;

  modport master (
    output flush, in_valid, in_real, in_imag, fb_real, fb_imag,
    input  dly_real, dly_imag, sel, out_valid, phase_cnt
  );

  modport slave (
    input  flush, in_valid, in_real, in_imag, fb_real, fb_imag,
    output dly_real, dly_imag, sel, out_valid, phase_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fft_sdf_delay_buffer.sv
`default_nettype none
// ============================================================================
// fft_sdf_delay_buffer : radix-2 SDF stage delay line, phase counter and mux select
// Rev 1.0 -- optional output register stage: SDF_DLY_REG_OUT_EN
// ============================================================================
module fft_sdf_delay_buffer #(
  parameter int WL    = 18,
  parameter int DEPTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fft_sdf_delay_buffer_if.slave      bus
);

  localparam logic [0:0]     ST_FILL   = 1'b0;
  localparam logic [0:0]     ST_PRIMED = 1'b1;
  localparam logic [CNT_W:0] LAST_FILL = (CNT_W+1)'(DEPTH - 1);
  localparam logic [CNT_W:0] CNT_ONE   = (CNT_W+1)'(1);

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [CNT_W:0]      phase;
  logic                half_sel;
  logic                primed;
  logic                accept;
  logic signed [WL:0]  wr_real;
  logic signed [WL:0]  wr_imag;
  logic signed [WL:0]  line_real [DEPTH];
  logic signed [WL:0]  line_imag [DEPTH];

  // flush suppresses the sample presented on the same edge
  assign accept   = bus.in_valid & ~bus.flush;
  assign half_sel = phase[CNT_W];
  assign wr_real  = half_sel ? bus.fb_real : bus.in_real;
  assign wr_imag  = half_sel ? bus.fb_imag : bus.in_imag;

  // 2*DEPTH is a power of two, so the counter wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (bus.flush) begin
      phase <= '0;
    end else if (bus.in_valid) begin
      phase <= phase + CNT_ONE;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          line_real[i] <= '0;
          line_imag[i] <= '0;
        end else if (accept) begin
          if (i == 0) begin
            line_real[i] <= wr_real;
            line_imag[i] <= wr_imag;
          end else begin
            line_real[i] <= line_real[(i > 0) ? i - 1 : 0];
            line_imag[i] <= line_imag[(i > 0) ? i - 1 : 0];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // FILL lasts exactly DEPTH accepted samples since phase restarts at 0 on entry
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_FILL;
    end else if (state == ST_FILL && bus.in_valid && phase == LAST_FILL) begin
      state_nxt = ST_PRIMED;
    end
  end

  always_comb begin
    primed = 1'b0;
    if (state == ST_PRIMED) begin
      primed = 1'b1;
    end
  end

  assign bus.phase_cnt = phase;

`ifdef SDF_DLY_REG_OUT_EN
  logic signed [WL:0] out_real;
  logic signed [WL:0] out_imag;
  logic               out_sel;
  logic               out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_real <= '0;
      out_imag <= '0;
      out_sel  <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      out_real <= line_real[DEPTH-1];
      out_imag <= line_imag[DEPTH-1];
      out_sel  <= half_sel;
      out_vld  <= primed;
    end
  end

  assign bus.dly_real  = out_real;
  assign bus.dly_imag  = out_imag;
  assign bus.sel       = out_sel;
  assign bus.out_valid = out_vld;
`else
  assign bus.dly_real  = line_real[DEPTH-1];
  assign bus.dly_imag  = line_imag[DEPTH-1];
  assign bus.sel       = half_sel;
  assign bus.out_valid = primed;
`endif

endmodule
`default_nettype wire

// File: doc/fft_sdf_delay_buffer.md
# fft_sdf_delay_buffer

Complex delay-feedback buffer and stage sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage. Holds DEPTH complex S7.11 samples in a shift-register delay line, sequences fill/butterfly half-frames, and drives the `control` select of the downstream 19-bit complex 2:1 mux. The mux chooses between the delayed sample and the butterfly result. Sits between the stage input and the butterfly and mux, and closes the feedback loop through `fb_*`.

## Interface
- `WL`, 18, data MSB index; samples are WL+1 = 19 bits, signed S7.11
- `DEPTH`, 16, delay-line length in complex samples; power of two, at least 2
- `CNT_W`, 4, log2(DEPTH)
- `clk`  input  1  rising-edge clock, sole clock domain
- `rst_n`  input  1  asynchronous active-low reset
- `flush`  input  1  synchronous frame restart
- `in_valid`  input  1  input sample strobe; one sample is accepted per cycle when high
- `in_real`, `in_imag`  input  WL+1  stage input sample, signed
- `fb_real`, `fb_imag`  input  WL+1  butterfly difference output, written back into the delay line, signed
- `dly_real`, `dly_imag`  output  WL+1  oldest delay-line entry, signed
- `sel`  output  1  mux control: 0 = fill half, 1 = butterfly half
- `out_valid`  output  1  `dly_*` holds a sample written after the last reset/flush
- `phase_cnt`  output  CNT_W+1  sample index within the current 2·DEPTH frame

## Operation
- `phase_cnt` increments on each accepted sample (`in_valid` = 1).
  - It wraps from 2·DEPTH−1 to 0.
  - `sel` = `phase_cnt[CNT_W]`.
- Delay line: DEPTH-entry shift register of complex words. It shifts only on an accepted sample. Entry 0 receives the write data; entry DEPTH−1 drives `dly_*`.
- Write data: `in_*` when `sel` = 0, and `fb_*` when `sel` = 1. The value of `sel` used is the one before the increment.
- Occupancy state machine:
  - FILL → PRIMED once DEPTH samples have been accepted in FILL. The transition is taken on the edge accepting the DEPTH-th sample.
  - PRIMED stays PRIMED until reset or flush.
  - `out_valid` = 1 in PRIMED only.
- `flush` = 1 at an edge has these effects:
  - `phase_cnt` → 0 and state → FILL.
  - Delay contents are retained but treated as stale: `out_valid` = 0.
  - `flush` wins over a simultaneous `in_valid`; that sample is dropped and no shift occurs.
- `in_valid` = 0: all registers hold, including mid-frame.
- Data is pass-through only. No arithmetic, no width change; the full 19-bit sign is preserved.
- Reset (`rst_n` low, asynchronous):
  - All delay entries = 0, `dly_*` = 0, `sel` = 0, `phase_cnt` = 0, `out_valid` = 0, state = FILL.
  - Reset asserted mid-frame discards the frame. The first sample after release is index 0.

## Timing
- Accepted sample k appears on `dly_*` in the cycle after the edge that accepted sample k+DEPTH−1, so latency is DEPTH accepted samples.
- `sel` and `phase_cnt` update on the accepting edge. They are registered, with no combinational path from `in_valid`.
- `dly_*` comes straight from register entry DEPTH−1; there is no input-to-output combinational path.
- Back-to-back `in_valid` sustains one sample per cycle. Gaps simply stretch the frame.

## Configuration
- Macro `SDF_DLY_REG_OUT_EN`.
  - Defined: adds one output register on `dly_*`, `sel` and `out_valid`, all loaded every cycle. Every output appears 1 cycle later relative to the accepting edge; reset value 0. `phase_cnt` is unaffected.
  - Undefined: outputs exactly as in Timing above.

## Test plan
- Reset and no stimulus, with `rst_n` held low: every output reads 0, including when `rst_n` falls mid-clock.
- DEPTH = 4 fill, samples in_real = 1..4 (imag = −1..−4) with `in_valid` continuous:
  - `out_valid` rises after the 4th edge.
  - `dly_real` = 1 and `dly_imag` = −1 after the 4th accepting edge.
  - `sel` = 1 from the 5th sample.
- Feedback half, DEPTH = 4: samples 5..8 with `fb_real` = 100+k. Samples 9..12 then show `dly_real` = 105..108 and `sel` = 0. `phase_cnt` wraps 7 → 0.
- Gapped input: `in_valid` toggles every other cycle. `phase_cnt`, `sel` and `dly_*` hold on idle cycles, and the data order is identical to the continuous case.
- Flush at `phase_cnt` = 6 with `in_valid` = 1:
  - That sample is dropped and `phase_cnt` = 0.
  - `out_valid` = 0 until 4 new samples are accepted.
- With `SDF_DLY_REG_OUT_EN` defined, the fill test shows `dly_real` = 1 and `out_valid` = 1 one cycle later than without the macro.
